// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Two-master arbiter in front of a single-port 32-bit SRAM macro. A granted
//   master drives the macro in the same cycle. A granted read returns its data
//   one cycle later, flagged by that master's RVALID. A master can hold the
//   grant over several cycles with LOCK, for at most MAX_BURST grants.
//
//   Configuration macro:
//     SRAM_ARB_RR_EN  defined   : IDLE ties go to the master that was not
//                                 granted last (round-robin)
//                     undefined : IDLE ties always go to M0 (fixed priority)
//
//   Parameters:
//     AW         SRAM byte-address width (word address is AW-2 bits)
//     MAX_BURST  maximum consecutive locked grants to one master (1..255)
//
//   Ports:
//     HCLK, HRESET        clock, synchronous active-high reset
//     Mn_REQ              access request from master n
//     Mn_LOCK             hold the grant for the following access
//     Mn_WEN[3:0]         byte write enables, 0 = read
//     Mn_ADDR[AW-3:0]     word address
//     Mn_WDATA[31:0]      write data
//     Mn_GNT              access accepted this cycle (combinational)
//     Mn_RVALID           read data valid for master n
//     Mn_RDATA[31:0]      read data (SRAMRDATA, qualified by Mn_RVALID)
//     SRAMRDATA[31:0]     macro read data, one cycle after a read CS
//     SRAMCS, SRAMWEN, SRAMWDATA, SRAMADDR   macro controls
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int AW        = 12,
  parameter int MAX_BURST = 8
) (
  input  logic          HCLK,
  input  logic          HRESET,

  input  logic          M0_REQ,
  input  logic          M0_LOCK,
  input  logic [3:0]    M0_WEN,
  input  logic [AW-3:0] M0_ADDR,
  input  logic [31:0]   M0_WDATA,
  output logic          M0_GNT,
  output logic          M0_RVALID,
  output logic [31:0]   M0_RDATA,

  input  logic          M1_REQ,
  input  logic          M1_LOCK,
  input  logic [3:0]    M1_WEN,
  input  logic [AW-3:0] M1_ADDR,
  input  logic [31:0]   M1_WDATA,
  output logic          M1_GNT,
  output logic          M1_RVALID,
  output logic [31:0]   M1_RDATA,

  input  logic [31:0]   SRAMRDATA,
  output logic          SRAMCS,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic [AW-3:0] SRAMADDR
);

`ifdef SRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [7:0] MAX_B    = 8'(MAX_BURST);
  localparam bit         BURST_EN = (MAX_BURST > 1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt, cnt_inc;
  logic       last;
  logic       tie_m1;
  logic       gnt0, gnt1;
  logic       vld0_p1, vld1_p1;

  assign cnt_inc = cnt + 8'd1;
  // last==1 means M1 was served last, so M0 wins the next tie under round-robin.
  assign tie_m1  = RR_EN & ~last;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (M0_REQ && (!M1_REQ || !tie_m1)) gnt0 = 1'b1;
        else if (M1_REQ)                    gnt1 = 1'b1;
        if (gnt0 && M0_LOCK && BURST_EN) begin
          state_nxt = LOCK0;
          cnt_nxt   = 8'd1;
        end else if (gnt1 && M1_LOCK && BURST_EN) begin
          state_nxt = LOCK1;
          cnt_nxt   = 8'd1;
        end else begin
          cnt_nxt   = 8'd0;
        end
      end
      LOCK0: begin
        // The other master is held off; a missing request ends the lock with a bubble.
        if (M0_REQ) begin
          gnt0 = 1'b1;
          if (M0_LOCK && (cnt_inc < MAX_B)) begin
            cnt_nxt = cnt_inc;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end
      end
      LOCK1: begin
        if (M1_REQ) begin
          gnt1 = 1'b1;
          if (M1_LOCK && (cnt_inc < MAX_B)) begin
            cnt_nxt = cnt_inc;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
    if (HRESET) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      last    <= 1'b1;
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      if (gnt0)      last <= 1'b0;
      else if (gnt1) last <= 1'b1;
      vld0_p1 <= gnt0 & (M0_WEN == 4'h0);
      vld1_p1 <= gnt1 & (M1_WEN == 4'h0);
    end
  end

  // Stage p0: grant drives the macro in the same cycle.
  assign M0_GNT    = gnt0;
  assign M1_GNT    = gnt1;
  assign SRAMCS    = gnt0 | gnt1;
  assign SRAMWEN   = gnt0 ? M0_WEN   : (gnt1 ? M1_WEN   : 4'h0);
  assign SRAMWDATA = gnt0 ? M0_WDATA : (gnt1 ? M1_WDATA : 32'h0);
  assign SRAMADDR  = gnt0 ? M0_ADDR  : (gnt1 ? M1_ADDR  : '0);

  // Stage p1: read data returns from the macro. A reset cycle swallows a
  // pending response so an abandoned burst never delivers data.
  assign M0_RVALID = vld0_p1 & ~HRESET;
  assign M1_RVALID = vld1_p1 & ~HRESET;
  assign M0_RDATA  = SRAMRDATA;
  assign M1_RDATA  = SRAMRDATA;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  localparam int AW = 12;
  localparam int WA = AW - 2;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          HCLK, HRESET;
  logic          M0_REQ, M0_LOCK, M1_REQ, M1_LOCK;
  logic [3:0]    M0_WEN, M1_WEN;
  logic [WA-1:0] M0_ADDR, M1_ADDR;
  logic [31:0]   M0_WDATA, M1_WDATA;
  logic          M0_GNT, M1_GNT, M0_RVALID, M1_RVALID;
  logic [31:0]   M0_RDATA, M1_RDATA;
  logic [31:0]   SRAMRDATA;
  logic          SRAMCS;
  logic [3:0]    SRAMWEN;
  logic [31:0]   SRAMWDATA;
  logic [WA-1:0] SRAMADDR;

  sram_arbiter #(.AW(AW), .MAX_BURST(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_REQ(M0_REQ), .M0_LOCK(M0_LOCK), .M0_WEN(M0_WEN), .M0_ADDR(M0_ADDR),
    .M0_WDATA(M0_WDATA), .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID), .M0_RDATA(M0_RDATA),
    .M1_REQ(M1_REQ), .M1_LOCK(M1_LOCK), .M1_WEN(M1_WEN), .M1_ADDR(M1_ADDR),
    .M1_WDATA(M1_WDATA), .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID), .M1_RDATA(M1_RDATA),
    .SRAMRDATA(SRAMRDATA), .SRAMCS(SRAMCS), .SRAMWEN(SRAMWEN),
    .SRAMWDATA(SRAMWDATA), .SRAMADDR(SRAMADDR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // SRAM macro model: one-cycle read latency, byte-enabled writes.
  logic [31:0] mem [0:(1<<WA)-1];
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'h0) SRAMRDATA <= mem[SRAMADDR];
      else for (int b = 0; b < 4; b++)
        if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
    end
  end

  typedef struct { int cyc; int m; logic [WA-1:0] addr; logic [3:0] wen; logic [31:0] wdata; } gexp_t;
  typedef struct { int cyc; int m; logic [31:0] data; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  logic [31:0] ref_mem [0:(1<<WA)-1];

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or read response.
  always @(negedge HCLK) begin
    if (mon_en) begin
      if (M0_GNT || M1_GNT || SRAMCS) begin
        check("gnt_onehot", 64'(M0_GNT & M1_GNT), 64'(0));
        if (gq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_grant at cycle %0d: got M0_GNT=%0b M1_GNT=%0b, expected none", cyc, M0_GNT, M1_GNT);
        end else begin
          gexp_t e;
          e = gq.pop_front();
          check("gnt_cycle", 64'(cyc), 64'(e.cyc));
          check("gnt_master", 64'({M1_GNT, M0_GNT}), 64'(e.m == 1 ? 2'b10 : 2'b01));
          check("gnt_req", 64'(M1_GNT ? M1_REQ : M0_REQ), 64'(1));
          check("sram_cs", 64'(SRAMCS), 64'(1));
          check("sram_addr", 64'(SRAMADDR), 64'(e.addr));
          check("sram_wen", 64'(SRAMWEN), 64'(e.wen));
          check("sram_wdata", 64'(SRAMWDATA), 64'(e.wdata));
        end
      end else begin
        check("idle_sram_zero", 64'({SRAMWEN, SRAMWDATA, SRAMADDR}), 64'(0));
      end
      if (M0_RVALID || M1_RVALID) begin
        check("rvalid_onehot", 64'(M0_RVALID & M1_RVALID), 64'(0));
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rvalid at cycle %0d: got M0_RVALID=%0b M1_RVALID=%0b, expected none", cyc, M0_RVALID, M1_RVALID);
        end else begin
          rexp_t r;
          r = rq.pop_front();
          check("rvalid_cycle", 64'(cyc), 64'(r.cyc));
          check("rvalid_master", 64'({M1_RVALID, M0_RVALID}), 64'(r.m == 1 ? 2'b10 : 2'b01));
          check("rdata", 64'(r.m == 1 ? M1_RDATA : M0_RDATA), 64'(r.data));
        end
      end
    end
  end

  task automatic m0(input bit req, input bit lock, input logic [3:0] wen, input logic [WA-1:0] addr, input logic [31:0] wd);
    M0_REQ = req; M0_LOCK = lock; M0_WEN = wen; M0_ADDR = addr; M0_WDATA = wd;
  endtask

  task automatic m1(input bit req, input bit lock, input logic [3:0] wen, input logic [WA-1:0] addr, input logic [31:0] wd);
    M1_REQ = req; M1_LOCK = lock; M1_WEN = wen; M1_ADDR = addr; M1_WDATA = wd;
  endtask

  task automatic idle_all();
    m0(1'b0, 1'b0, 4'h0, '0, 32'h0);
    m1(1'b0, 1'b0, 4'h0, '0, 32'h0);
  endtask

  // Push the expected outcome of the current cycle, then advance one clock.
  // exp_m: -1 no grant, 0/1 granted master. rd_kill: a reset follows, so no response.
  task automatic step(input int exp_m, input bit rd_kill);
    if (exp_m >= 0) begin
      gexp_t g;
      g.cyc   = cyc;
      g.m     = exp_m;
      g.addr  = (exp_m == 1) ? M1_ADDR  : M0_ADDR;
      g.wen   = (exp_m == 1) ? M1_WEN   : M0_WEN;
      g.wdata = (exp_m == 1) ? M1_WDATA : M0_WDATA;
      gq.push_back(g);
      if (g.wen == 4'h0) begin
        if (!rd_kill) begin
          rexp_t r;
          r.cyc  = cyc + 1;
          r.m    = exp_m;
          r.data = ref_mem[g.addr];
          rq.push_back(r);
        end
      end else begin
        for (int b = 0; b < 4; b++)
          if (g.wen[b]) ref_mem[g.addr][8*b +: 8] = g.wdata[8*b +: 8];
      end
    end
    @(posedge HCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    idle_all();
    @(posedge HCLK); #1;
    mon_en = 1'b1;
    // Requests during reset must not be granted.
    m0(1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
    m1(1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
    #1;
    check("rst_m0_gnt", 64'(M0_GNT), 64'(0));
    check("rst_m1_gnt", 64'(M1_GNT), 64'(0));
    check("rst_sramcs", 64'(SRAMCS), 64'(0));
    check("rst_m0_rvalid", 64'(M0_RVALID), 64'(0));
    check("rst_m1_rvalid", 64'(M1_RVALID), 64'(0));
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Write by M0, then M1 reads the same word back.
    idle_all(); m0(1'b1, 1'b0, 4'hF, 10'h010, 32'hDEADBEEF); step(0, 1'b0);
    idle_all(); m1(1'b1, 1'b0, 4'h0, 10'h010, 32'h0);        step(1, 1'b0);
    idle_all();                                              step(-1, 1'b0);

    // More writes, a partial byte write, and read-after-write to the same word.
    idle_all(); m1(1'b1, 1'b0, 4'hF, 10'h020, 32'h11223344); step(1, 1'b0);
    idle_all(); m0(1'b1, 1'b0, 4'hF, 10'h021, 32'h55667788); step(0, 1'b0);
    idle_all(); m1(1'b1, 1'b0, 4'h3, 10'h020, 32'hAAAABBBB); step(1, 1'b0);
    idle_all(); m0(1'b1, 1'b0, 4'hF, 10'h030, 32'hCAFEF00D); step(0, 1'b0);
    idle_all(); m0(1'b1, 1'b0, 4'h0, 10'h030, 32'h0);        step(0, 1'b0);
    idle_all(); m1(1'b1, 1'b0, 4'h0, 10'h020, 32'h0);        step(1, 1'b0);

    // Both masters read unlocked for four cycles (M1 served last before this).
    for (int i = 0; i < 4; i++) begin
      m0(1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
      m1(1'b1, 1'b0, 4'h0, 10'h021, 32'h0);
      step(RR ? (i % 2) : 0, 1'b0);
    end
    idle_all(); step(-1, 1'b0);

    // M0 locked burst against a constant M1 request, capped at three grants.
    for (int i = 0; i < 4; i++) begin
      m0(1'b1, 1'b1, 4'hF, 10'h040 + 10'(i), 32'h40000000 + 32'(i));
      m1(1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
      step((i < 3) ? 0 : (RR ? 1 : 0), 1'b0);
    end
    idle_all(); step(-1, 1'b0);
    idle_all(); step(-1, 1'b0);

    // M1 lock holds M0 off, then M1 drops REQ: one bubble, then M0.
    idle_all(); m1(1'b1, 1'b1, 4'h0, 10'h020, 32'h0); step(1, 1'b0);
    m0(1'b1, 1'b0, 4'h0, 10'h010, 32'h0); m1(1'b1, 1'b1, 4'h0, 10'h021, 32'h0); step(1, 1'b0);
    m0(1'b1, 1'b0, 4'h0, 10'h010, 32'h0); m1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0); step(-1, 1'b0);
    m0(1'b1, 1'b0, 4'h0, 10'h010, 32'h0); step(0, 1'b0);
    idle_all(); step(-1, 1'b0);

    // Reset in the second cycle of an M0 locked read burst; then a tie goes to M0.
    idle_all(); m0(1'b1, 1'b1, 4'h0, 10'h010, 32'h0); step(0, 1'b1);
    HRESET = 1'b1;
    m0(1'b1, 1'b1, 4'h0, 10'h010, 32'h0); m1(1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
    #1;
    check("midrst_m0_gnt", 64'(M0_GNT), 64'(0));
    check("midrst_m1_gnt", 64'(M1_GNT), 64'(0));
    check("midrst_sramcs", 64'(SRAMCS), 64'(0));
    check("midrst_m0_rvalid", 64'(M0_RVALID), 64'(0));
    step(-1, 1'b0);
    HRESET = 1'b0;
    m0(1'b1, 1'b0, 4'h0, 10'h010, 32'h0); m1(1'b1, 1'b0, 4'h0, 10'h020, 32'h0); step(0, 1'b0);
    idle_all(); step(-1, 1'b0);

    // Reset abandons the lock: M0 silent afterwards, M1 served at once.
    idle_all(); m0(1'b1, 1'b1, 4'h0, 10'h021, 32'h0); step(0, 1'b1);
    HRESET = 1'b1; idle_all(); step(-1, 1'b0);
    HRESET = 1'b0; idle_all(); m1(1'b1, 1'b0, 4'h0, 10'h020, 32'h0); step(1, 1'b0);
    check("after_rst_m0_rvalid", 64'(M0_RVALID), 64'(0));
    idle_all(); step(-1, 1'b0);
    step(-1, 1'b0);
    step(-1, 1'b0);

    check("grant_queue_drained", 64'(gq.size()), 64'(0));
    check("read_queue_drained", 64'(rq.size()), 64'(0));
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
